// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side feeder.
package uart_pkg;

  // Default byte width, matching the transmitter's data_in.
  localparam int unsigned DataWDefault = 8;

  // Default FIFO depth.
  localparam int unsigned DepthDefault = 16;

  // Feeder sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } tx_feed_state_t;

  // Width of a counter that must hold values 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with occupancy count and sticky overflow flag.
// The storage array is not reset; only pointers, level and flags are.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = DepthDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            overflow_q, overflow_d;

  logic push;
  logic pop;

  // Flags derive from the registered level, so a push is judged against the pre-edge fill.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LvlW'(DEPTH));
  end

  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  // Next-state for pointers, level and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A dropped push takes priority over a same-cycle clear.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and frame sequencer feeding uart_transmitter.
// Bytes are queued in a FIFO and handed over one at a time with a single-cycle
// load strobe, paced by the transmitter's busy flag plus an optional idle gap.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = DepthDefault,
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_ovf,
  input  logic                   tx_busy,
  output logic                   tx_load,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned GapW = cnt_width(GAP_CYCLES);
  localparam logic [GapW-1:0] GapInit = GapW'(GAP_CYCLES);

  tx_feed_state_t    state_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              pop;

  // A byte leaves the FIFO only from IDLE with data present and the transmitter free.
  assign pop = (state_q == IDLE) && !empty && !tx_busy;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .clr_ovf  (clr_ovf),
    .rd_data  (fifo_rd_data),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  // Sequencer: load, hold one cycle past busy-rise latency, wait for frame end, then gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_load   <= 1'b0;
      tx_data   <= '0;
      gap_cnt_q <= '0;
    end else begin
      tx_load <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data <= fifo_rd_data;
            tx_load <= 1'b1;
            state_q <= HOLD;
          end
        end
        // Busy is ignored here: the transmitter raises it one cycle after the load.
        HOLD: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (!tx_busy) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= GapInit;
              state_q   <= GAP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        // Counts down from GAP_CYCLES; returns to IDLE after exactly that many cycles.
        GAP: begin
          if (gap_cnt_q <= GapW'(1)) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the handshake and occupancy.
  a_load_single: assert property (@(posedge clk) disable iff (!rst) tx_load |=> !tx_load);
  a_level_bound: assert property (@(posedge clk) disable iff (!rst) 32'(level) <= DEPTH);
  a_load_free:   assert property (@(posedge clk) disable iff (!rst)
                                  (state_q == IDLE && tx_busy) |=> !tx_load);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder, checking two instances
// (no gap and a four-cycle gap) against a timestamp-based reference model.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          clr_ovf;
  logic          tx_busy;

  logic          ld   [2];
  logic [DW-1:0] dat  [2];
  logic [4:0]    lvl  [2];
  logic          emp  [2];
  logic          ful  [2];
  logic          ovf  [2];

  int gap_of [2] = '{0, 4};

  uart_tx_feeder #(
    .DEPTH      (DEPTH),
    .DATA_W     (DW),
    .GAP_CYCLES (0)
  ) u_dut_g0 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_load  (ld[0]),
    .tx_data  (dat[0]),
    .level    (lvl[0]),
    .empty    (emp[0]),
    .full     (ful[0]),
    .overflow (ovf[0])
  );

  uart_tx_feeder #(
    .DEPTH      (DEPTH),
    .DATA_W     (DW),
    .GAP_CYCLES (4)
  ) u_dut_g4 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_load  (ld[1]),
    .tx_data  (dat[1]),
    .level    (lvl[1]),
    .empty    (emp[1]),
    .full     (ful[1]),
    .overflow (ovf[1])
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue contents plus timestamps of when the next load may occur.
  logic [DW-1:0] mq      [2][DEPTH];
  int            mq_cnt  [2];
  logic          m_ovf   [2];
  logic          m_load  [2];
  logic [DW-1:0] m_data  [2];
  bit            m_search[2];
  longint        m_search_from [2];
  longint        m_next_ok     [2];
  longint        edge_no = 0;

  // Observed load history.
  logic [DW-1:0] loads0 [$];
  longint        ldt0   [$];
  longint        ldt1   [$];

  bit busy_react = 0;
  int busy_hold  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq_cnt[i]        = 0;
      m_ovf[i]         = 1'b0;
      m_load[i]        = 1'b0;
      m_data[i]        = '0;
      m_search[i]      = 1'b0;
      m_search_from[i] = 0;
      m_next_ok[i]     = 0;
    end
  endtask

  // Predict the registered outputs after edge number t from the pre-edge inputs.
  task automatic model_edge(input longint t);
    for (int i = 0; i < 2; i++) begin
      bit full_pre;
      bit empty_pre;
      bit popped;
      full_pre  = (mq_cnt[i] == DEPTH);
      empty_pre = (mq_cnt[i] == 0);
      popped    = 1'b0;
      if (m_search[i] && t >= m_search_from[i] && !tx_busy) begin
        // Frame over: the next load decision is allowed after the gap.
        m_search[i]  = 1'b0;
        m_next_ok[i] = t + 1 + gap_of[i];
      end else if (!m_search[i] && t >= m_next_ok[i] && !empty_pre && !tx_busy) begin
        popped    = 1'b1;
        m_data[i] = mq[i][0];
        for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
        mq_cnt[i]--;
        m_search[i]      = 1'b1;
        // Busy is not looked at during the cycle the load is presented.
        m_search_from[i] = t + 2;
      end
      m_load[i] = popped;
      if (wr_en && full_pre) m_ovf[i] = 1'b1;
      else if (clr_ovf)      m_ovf[i] = 1'b0;
      if (wr_en && !full_pre) begin
        mq[i][mq_cnt[i]] = wr_data;
        mq_cnt[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("g%0d_tx_load", gap_of[i]),  32'(ld[i]),  32'(m_load[i]));
      check_val($sformatf("g%0d_tx_data", gap_of[i]),  32'(dat[i]), 32'(m_data[i]));
      check_val($sformatf("g%0d_level", gap_of[i]),    32'(lvl[i]), 32'(mq_cnt[i]));
      check_val($sformatf("g%0d_empty", gap_of[i]),    32'(emp[i]), 32'(mq_cnt[i] == 0));
      check_val($sformatf("g%0d_full", gap_of[i]),     32'(ful[i]), 32'(mq_cnt[i] == DEPTH));
      check_val($sformatf("g%0d_overflow", gap_of[i]), 32'(ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  // One clock: predict, advance, sample 1ns after the edge, then update busy stimulus.
  task automatic tick();
    edge_no++;
    if (rst) model_edge(edge_no);
    @(posedge clk);
    #1;
    compare_all();
    if (ld[0]) begin
      loads0.push_back(dat[0]);
      ldt0.push_back(edge_no);
    end
    if (ld[1]) ldt1.push_back(edge_no);
    if (busy_react) begin
      if (m_load[0]) busy_hold = 10;
      else if (busy_hold > 0) busy_hold--;
      tx_busy = (busy_hold > 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_hist();
    loads0.delete();
    ldt0.delete();
    ldt1.delete();
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    clr_ovf = 1'b0;
    tx_busy = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single byte with an idle transmitter.
    push_byte(8'hA5);
    ticks(8);
    check_val("single_loads", 32'(loads0.size()), 32'd1);
    if (loads0.size() >= 1) check_val("single_data", 32'(loads0[0]), 32'hA5);

    // Burst paced by a busy transmitter.
    clear_hist();
    busy_react = 1;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    ticks(60);
    busy_react = 0;
    tx_busy    = 1'b0;
    check_val("burst_loads", 32'(loads0.size()), 32'd3);
    for (int k = 0; k < loads0.size() && k < 3; k++)
      check_val($sformatf("burst_byte%0d", k), 32'(loads0[k]), 32'(k + 1));
    ticks(20);

    // Load spacing with busy held low.
    clear_hist();
    push_byte(8'h5A);
    push_byte(8'hC3);
    ticks(20);
    check_val("gap_loads", 32'(ldt1.size()), 32'd2);
    if (ldt1.size() >= 2) check_val("gap_spacing", 32'(ldt1[1] - ldt1[0]), 32'd7);
    check_val("nogap_loads", 32'(ldt0.size()), 32'd2);
    if (ldt0.size() >= 2) check_val("nogap_spacing", 32'(ldt0[1] - ldt0[0]), 32'd3);

    // Fill past capacity while the transmitter is busy, then drain across the wrap.
    clear_hist();
    tx_busy = 1'b1;
    for (int k = 1; k <= 17; k++) push_byte(8'(k));
    check_val("fill_full", 32'(ful[0]), 32'd1);
    check_val("fill_level", 32'(lvl[0]), 32'd16);
    check_val("fill_ovf", 32'(ovf[0]), 32'd1);
    tx_busy = 1'b0;
    ticks(130);
    check_val("drain_loads", 32'(loads0.size()), 32'd16);
    for (int k = 0; k < loads0.size() && k < 16; k++)
      check_val($sformatf("drain_byte%0d", k), 32'(loads0[k]), 32'(k + 1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_val("ovf_cleared", 32'(ovf[0]), 32'd0);

    // Overflow set and clear together: set wins.
    tx_busy = 1'b1;
    for (int k = 0; k < 16; k++) push_byte(8'($urandom));
    clr_ovf = 1'b1;
    push_byte(8'hEE);
    clr_ovf = 1'b0;
    check_val("ovf_set_wins", 32'(ovf[0]), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tx_busy = 1'b0;
    ticks(130);

    // Push and pop on the same edge at level 5.
    tx_busy = 1'b1;
    for (int k = 0; k < 5; k++) push_byte(8'($urandom));
    tx_busy = 1'b0;
    wr_en   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    ticks(120);

    // Reset in the middle of a paced burst.
    busy_react = 1;
    for (int k = 0; k < 8; k++) push_byte(8'(8'h40 + k));
    ticks(2);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("rst_tx_load", 32'(ld[0]), 32'd0);
    check_val("rst_level", 32'(lvl[0]), 32'd0);
    check_val("rst_empty", 32'(emp[0]), 32'd1);
    ticks(3);
    rst        = 1'b1;
    busy_react = 0;
    busy_hold  = 0;
    tx_busy    = 1'b0;
    clear_hist();
    ticks(10);
    check_val("post_rst_quiet", 32'(ldt0.size() + ldt1.size()), 32'd0);
    push_byte(8'h99);
    ticks(6);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom);
      clr_ovf = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) tx_busy = ~tx_busy;
      tick();
    end
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    tx_busy = 1'b0;
    ticks(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
